// File: rtl/mem_stage_cache_if.sv
// Backing-memory line bus for mem_stage_cache.
//   master (cache side): drives mem_req, mem_we, mem_addr, mem_wdata; receives mem_rdata, mem_ready
//   slave  (memory side): the mirror image
// A request is held stable until the edge on which mem_ready=1 completes it.
interface mem_stage_cache_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
);
    logic                             mem_req;
    logic                             mem_we;
    logic [DATA_WIDTH-1:0]            mem_addr;
    logic [LINE_WORDS*DATA_WIDTH-1:0] mem_wdata;
    logic [LINE_WORDS*DATA_WIDTH-1:0] mem_rdata;
    logic                             mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage_cache.sv
// Memory pipeline stage with a write-back, write-allocate, N-way set-associative data cache.
// Hits are looked up combinationally (load data same cycle, store commits at the next edge);
// misses raise stall while the victim is written back (if dirty) and the line is refilled.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ALUResult, WriteData             byte address / pass-through value, right-aligned store data
//   ResultSrc, MemWrite, MemRead     result select, store and load requests
//   funct3                           RV32I access size and sign
//   Result, stall                    writeback value, pipeline hold
//   mem                              line bus to backing memory (mem_stage_cache_if.master)
//   hit_count, miss_count            performance counters
// Optional feature: define MEM_STAGE_PERF_EN to build the counters; otherwise they read 0.
module mem_stage_cache #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  ResultSrc,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  stall,
    mem_stage_cache_if.master     mem,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int unsigned WordBits  = $clog2(LINE_WORDS);
    localparam int unsigned IndexBits = $clog2(SETS);
    localparam int unsigned OffBits   = 2 + WordBits;
    localparam int unsigned TagBits   = DATA_WIDTH - OffBits - IndexBits;
    localparam int unsigned WayBits   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WayBits-1:0]    victim_q, victim_d;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WayBits-1:0]    ptr_q   [SETS];
    logic [TagBits-1:0]    tag_q   [WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS][LINE_WORDS];

    logic [TagBits-1:0]    req_tag;
    logic [IndexBits-1:0]  req_idx;
    logic [WordBits-1:0]   req_word;
    logic [1:0]            req_byte;
    logic [DATA_WIDTH-1:0] line_addr;

    assign req_tag   = ALUResult[DATA_WIDTH-1 -: TagBits];
    assign req_idx   = ALUResult[OffBits +: IndexBits];
    assign req_word  = ALUResult[2 +: WordBits];
    assign req_byte  = ALUResult[1:0];
    assign line_addr = {req_tag, req_idx, {OffBits{1'b0}}};

    logic                  access, hit, idle_hit, load_hit, store_en, refill_done, victim_found;
    logic [WayBits-1:0]    hit_way, victim_way, ptr_inc;
    logic [DATA_WIDTH-1:0] hit_word, load_data, st_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    assign access   = MemRead | MemWrite;
    assign idle_hit = (state_q == StIdle) && hit;
    assign load_hit = MemRead & idle_hit;
    assign store_en = MemWrite & idle_hit;
    assign stall    = access & ~idle_hit;

    // Tag compare across all ways; victim is the lowest invalid way, else the round-robin pointer.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        victim_way   = ptr_q[req_idx];
        victim_found = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WayBits'(w);
            end
            if (!valid_q[req_idx][w] && !victim_found) begin
                victim_found = 1'b1;
                victim_way   = WayBits'(w);
            end
        end
        ptr_inc = (int'(ptr_q[req_idx]) == int'(WAYS) - 1) ? '0 : ptr_q[req_idx] + 1'b1;
    end

    assign hit_word = data_q[hit_way][req_idx][req_word];

    // Load extraction and store merge; misaligned accesses fall back to the aligned lane.
    always_comb begin
        ld_byte = hit_word[7:0];
        case (req_byte)
            2'd0: ld_byte = hit_word[7:0];
            2'd1: ld_byte = hit_word[15:8];
            2'd2: ld_byte = hit_word[23:16];
            2'd3: ld_byte = hit_word[31:24];
            default: ld_byte = hit_word[7:0];
        endcase
        ld_half = req_byte[1] ? hit_word[31:16] : hit_word[15:0];

        load_data = hit_word;
        case (funct3)
            3'b000: load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001: load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100: load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101: load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_data = hit_word;
        endcase
        if (!load_hit) begin
            load_data = '0;
        end

        st_word = hit_word;
        case (funct3)
            3'b000: begin
                case (req_byte)
                    2'd0: st_word[7:0]   = WriteData[7:0];
                    2'd1: st_word[15:8]  = WriteData[7:0];
                    2'd2: st_word[23:16] = WriteData[7:0];
                    2'd3: st_word[31:24] = WriteData[7:0];
                    default: st_word[7:0] = WriteData[7:0];
                endcase
            end
            3'b001: begin
                if (req_byte[1]) begin
                    st_word[31:16] = WriteData[15:0];
                end else begin
                    st_word[15:0] = WriteData[15:0];
                end
            end
            default: st_word = WriteData;
        endcase
    end

    assign Result = ResultSrc ? load_data : ALUResult;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        victim_d    = victim_q;
        refill_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access && !hit) begin
                    victim_d  = victim_way;
                    mem_req_d = 1'b1;
                    if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
                        state_d    = StWriteback;
                        mem_we_d   = 1'b1;
                        mem_addr_d = {tag_q[victim_way][req_idx], req_idx, {OffBits{1'b0}}};
                    end else begin
                        state_d    = StRefill;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_addr;
                    end
                end
            end
            StWriteback: begin
                if (mem.mem_ready) begin
                    // mem_req stays high; the refill address takes over on this edge
                    state_d    = StRefill;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr;
                end
            end
            StRefill: begin
                if (mem.mem_ready) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    refill_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            victim_q   <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            victim_q   <= victim_d;
            if (refill_done) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
                ptr_q[req_idx]             <= ptr_inc;
            end else if (store_en) begin
                dirty_q[req_idx][hit_way] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_q[victim_q][req_idx] <= req_tag;
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                data_q[victim_q][req_idx][i] <= mem.mem_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (store_en) begin
            data_q[hit_way][req_idx][req_word] <= st_word;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;

    // Victim line read straight from the array; nothing writes it during WRITEBACK.
    always_comb begin
        mem.mem_wdata = '0;
        for (int i = 0; i < int'(LINE_WORDS); i++) begin
            mem.mem_wdata[i*DATA_WIDTH +: DATA_WIDTH] = data_q[victim_q][req_idx][i];
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        retry_q;

    // The cycle right after a refill is the retried access; its hit is not counted.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (access && idle_hit && !retry_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if ((state_q == StIdle) && (state_d != StIdle)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            retry_q    <= refill_done;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
